// File: rtl/sprite_draw_engine_if.sv
// Arbiter-side handshake and pixel stream of one sprite draw engine.
interface sprite_draw_engine_if;
  logic       draw;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic [1:0] frame_sel;
  logic       hit;
  logic [8:0] x_draw;
  logic [7:0] y_draw;
  logic [5:0] colour;
  logic       VGA_write;
  logic       draw_done;

  modport master (
    output draw, x_pos, y_pos, frame_sel, hit,
    input  x_draw, y_draw, colour, VGA_write, draw_done
  );

  modport slave (
    input  draw, x_pos, y_pos, frame_sel, hit,
    output x_draw, y_draw, colour, VGA_write, draw_done
  );
endinterface

// File: rtl/sprite_draw_engine.sv
// Sprite pixel generator: walks the sprite ROM row-major and streams one
// clipped, optionally flashed pixel per cycle toward the VGA write port.
module sprite_draw_engine #(
  parameter int unsigned SPRITE_W     = 16,
  parameter int unsigned SPRITE_H     = 16,
  parameter logic [5:0]  TRANSPARENT  = 6'b000000,
  parameter logic [5:0]  FLASH_COLOUR = 6'b110000,
  parameter int unsigned SCREEN_W     = 320,
  parameter int unsigned SCREEN_H     = 240
) (
  input  logic                                             clock,
  input  logic                                             reset,
  sprite_draw_engine_if.slave                              bus,
  output logic [1+$clog2(SPRITE_W)+$clog2(SPRITE_H):0]     rom_addr,
  input  logic [5:0]                                       rom_data
);
  localparam int unsigned CW = $clog2(SPRITE_W);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned NW = CW + RW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] count_q, count_d;
  logic          drain_q, drain_d;
  logic [8:0]    x_lat_q, x_lat_d;
  logic [7:0]    y_lat_q, y_lat_d;
  logic [1:0]    frame_q, frame_d;
  logic          hit_q, hit_d;
  logic          s1_valid_q, s1_valid_d;
  logic [RW-1:0] s1_row_q, s1_row_d;
  logic [CW-1:0] s1_col_q, s1_col_d;
  logic [8:0]    x_draw_q, x_draw_d;
  logic [7:0]    y_draw_q, y_draw_d;
  logic [5:0]    colour_q, colour_d;
  logic          write_q, write_d;
  logic          done_q, done_d;

  logic          abort;
  logic          pix_valid;
  logic          opaque;
  logic [9:0]    x_sum;
  logic [8:0]    y_sum;

  assign rom_addr      = (state_q == RUN) ? {frame_q, count_q} : '0;
  assign bus.x_draw    = x_draw_q;
  assign bus.y_draw    = y_draw_q;
  assign bus.colour    = colour_q;
  assign bus.VGA_write = write_q;
  assign bus.draw_done = done_q;

  // Next-state logic for the FSM, address counter and the two pipeline stages.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drain_d    = drain_q;
    x_lat_d    = x_lat_q;
    y_lat_d    = y_lat_q;
    frame_d    = frame_q;
    hit_d      = hit_q;
    done_d     = done_q;
    s1_valid_d = 1'b0;
    s1_row_d   = count_q[NW-1:CW];
    s1_col_d   = count_q[CW-1:0];
    abort      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.draw) begin
          x_lat_d = bus.x_pos;
          y_lat_d = bus.y_pos;
          frame_d = bus.frame_sel;
          hit_d   = bus.hit;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.draw) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          s1_valid_d = 1'b1;
          count_d    = count_q + 1'b1;
          if (count_q == '1) begin
            drain_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!bus.draw) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (drain_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        if (!bus.draw) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An abort also squashes the pixel in flight so the strobe drops right
    // after the edge that sees draw low.
    pix_valid = s1_valid_q && !abort;
    opaque    = (rom_data != TRANSPARENT);
    x_sum     = {1'b0, x_lat_q} + 10'(s1_col_q);
    y_sum     = {1'b0, y_lat_q} + 9'(s1_row_q);
    if (pix_valid) begin
      x_draw_d = x_sum[8:0];
      y_draw_d = y_sum[7:0];
      colour_d = (hit_q && opaque) ? FLASH_COLOUR : rom_data;
      write_d  = opaque && (x_sum < 10'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));
    end else begin
      x_draw_d = '0;
      y_draw_d = '0;
      colour_d = '0;
      write_d  = 1'b0;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      drain_q    <= 1'b0;
      x_lat_q    <= '0;
      y_lat_q    <= '0;
      frame_q    <= '0;
      hit_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      x_draw_q   <= '0;
      y_draw_q   <= '0;
      colour_q   <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      x_lat_q    <= x_lat_d;
      y_lat_q    <= y_lat_d;
      frame_q    <= frame_d;
      hit_q      <= hit_d;
      s1_valid_q <= s1_valid_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      x_draw_q   <= x_draw_d;
      y_draw_q   <= y_draw_d;
      colour_q   <= colour_d;
      write_q    <= write_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboard bench for sprite_draw_engine: stimulus pushes expected pixel
// writes (with their cycle), a negedge monitor pops and compares each write.
module tb_sprite_draw_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rom_addr;
  logic [5:0] rom_data = '0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         nwrites = 0;
  int         rom_mode = 0;

  typedef struct {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } exp_t;
  exp_t q[$];

  sprite_draw_engine_if bus();

  sprite_draw_engine dut (
    .clock    (clk),
    .reset    (rst_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] rom_fn(input logic [9:0] a);
    if (rom_mode == 1) return a[0] ? 6'h2A : 6'h00;
    return 6'h15;
  endfunction

  // Synchronous sprite ROM model.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pixel strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.VGA_write === 1'b1) begin
      nwrites++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got x=%0d y=%0d c=%0h at cycle %0d, none expected",
                 bus.x_draw, bus.y_draw, bus.colour, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pixel{cyc,x,y,c}",
              {25'd0, cyc[15:0], bus.x_draw, bus.y_draw, bus.colour},
              {25'd0, e.cyc[15:0], e.x, e.y, e.c});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  // Raise draw now; the DUT accepts at the next edge T. Pixels k < npix
  // are expected, pixel k visible after edge T+2+k.
  task automatic start_draw(input logic [8:0] x, input logic [7:0] y, input logic [1:0] f,
                            input logic h, input int npix, output int t);
    logic [9:0] xs;
    logic [8:0] ys;
    logic [5:0] rv;
    logic [7:0] kk;
    bus.x_pos     = x;
    bus.y_pos     = y;
    bus.frame_sel = f;
    bus.hit       = h;
    bus.draw      = 1'b1;
    t = cyc + 1;
    nwrites = 0;
    for (int k = 0; k < 256; k++) begin
      if (k < npix) begin
        kk = k[7:0];
        xs = {1'b0, x} + {6'd0, kk[3:0]};
        ys = {1'b0, y} + {5'd0, kk[7:4]};
        rv = rom_fn({f, kk});
        if (rv != 6'h00 && xs < 10'd320 && ys < 9'd240)
          q.push_back('{t + 2 + k, xs[8:0], ys[7:0], h ? 6'h30 : rv});
      end
    end
  endtask

  task automatic finish_draw(input int t, input string name);
    wait_cyc(t + 257);
    check({name, "_done_early"}, {63'd0, bus.draw_done}, 64'd0);
    tick();
    check({name, "_done"}, {63'd0, bus.draw_done}, 64'd1);
    check({name, "_drain_quiet"}, {63'd0, bus.VGA_write}, 64'd0);
    tick();
    tick();
    check({name, "_done_held"}, {63'd0, bus.draw_done}, 64'd1);
    bus.draw = 1'b0;
    tick();
    check({name, "_done_clear"}, {63'd0, bus.draw_done}, 64'd0);
    tick();
  endtask

  initial begin
    int t;
    bit seen_done;
    rst_n         = 1'b0;
    bus.draw      = 1'b1;
    bus.x_pos     = 9'd5;
    bus.y_pos     = 8'd7;
    bus.frame_sel = 2'd3;
    bus.hit       = 1'b1;

    // Reset held with draw high: everything idle.
    tick(); tick(); tick();
    check("reset_outputs",
          {18'd0, bus.x_draw, bus.y_draw, bus.colour, bus.VGA_write, bus.draw_done, rom_addr},
          64'd0);

    // Release reset with draw high: basic draw starts at the next edge.
    rst_n = 1'b1;
    rom_mode = 0;
    start_draw(9'd100, 8'd50, 2'd2, 1'b0, 256, t);
    wait_cyc(t);
    check("rom_addr_first", {54'd0, rom_addr}, 64'd512);
    wait_cyc(t + 255);
    check("rom_addr_last", {54'd0, rom_addr}, 64'd767);
    finish_draw(t, "basic");
    check("basic_writes", 64'(nwrites), 64'd256);

    // Transparency and flash.
    rom_mode = 1;
    start_draw(9'd20, 8'd30, 2'd1, 1'b1, 256, t);
    wait_cyc(t + 2);
    check("even_slot", {57'd0, bus.VGA_write, bus.colour}, 64'd0);
    wait_cyc(t + 3);
    check("odd_flash_colour", {58'd0, bus.colour}, 64'h30);
    finish_draw(t, "flash");
    check("flash_writes", 64'(nwrites), 64'd128);

    // Clipping at the bottom-right corner.
    rom_mode = 0;
    start_draw(9'd310, 8'd230, 2'd0, 1'b0, 256, t);
    finish_draw(t, "clip");
    check("clip_writes", 64'(nwrites), 64'd100);

    // Abort: draw sampled low at edge T+40.
    start_draw(9'd0, 8'd0, 2'd3, 1'b0, 38, t);
    wait_cyc(t + 39);
    bus.draw = 1'b0;
    tick();
    check("abort_write_off", {63'd0, bus.VGA_write}, 64'd0);
    tick();
    check("abort_idle_addr", {54'd0, rom_addr}, 64'd0);
    seen_done = 1'b0;
    while (cyc < t + 262) begin
      if (bus.draw_done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", {63'd0, seen_done}, 64'd0);
    check("abort_writes", 64'(nwrites), 64'd38);
    start_draw(9'd40, 8'd60, 2'd0, 1'b0, 256, t);
    finish_draw(t, "redraw");
    check("redraw_writes", 64'(nwrites), 64'd256);

    // Position change during RUN ignored, then mid-transaction reset at T+100.
    start_draw(9'd50, 8'd20, 2'd1, 1'b0, 98, t);
    wait_cyc(t + 10);
    bus.x_pos = 9'd200;
    bus.y_pos = 8'd9;
    wait_cyc(t + 99);
    rst_n = 1'b0;
    tick();
    check("midreset_outputs",
          {18'd0, bus.x_draw, bus.y_draw, bus.colour, bus.VGA_write, bus.draw_done, rom_addr},
          64'd0);
    bus.draw = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check("midreset_writes", 64'(nwrites), 64'd98);
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
